biquad_hpf_multich: RTL and testbench

//  Time-multiplexed, multi-channel 2nd-order IIR high-pass (biquad) engine for the channel strip.
//  One frame = one sample per channel. Each frame uses one shared multiplier: 5 MAC cycles plus 1 writeback per channel.

---
 rtl/biquad_pkg.sv | 44 ++++
 rtl/biquad_coeff_rom.sv | 21 ++
 rtl/biquad_hpf_multich.sv | 197 +++++++++++++++++++
 tb/tb_biquad_hpf_multich.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// biquad_pkg
//   Shared types and the fixed coefficient table for the multi-channel
//   biquad high-pass engine.
//   coeff_t      signed Q(FRAC) coefficient, FRAC = 30
//   coeff_set_t  {b0, b1, b2, a1, a2}; a1/a2 carry their sign already
//   state_t      engine FSM states
//   coeff_lookup select -> coefficient set; selects above SEL_MAX are bypass
package biquad_pkg;

  localparam int COEFF_W = 32;
  localparam int NSETS   = 5;
  localparam logic [2:0] SEL_MAX = 3'd4;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  typedef struct packed {
    coeff_t b0;
    coeff_t b1;
    coeff_t b2;
    coeff_t a1;
    coeff_t a2;
  } coeff_set_t;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WB, DONE} state_t;

  // All values are exact dyadic fractions, so the Q30 integers are exact.
  function automatic coeff_set_t coeff_lookup(input logic [2:0] sel);
    coeff_set_t c;
    c = '{b0: 32'sd1073741824, b1: 32'sd0, b2: 32'sd0, a1: 32'sd0, a2: 32'sd0};
    case (sel)
      3'd1: c = '{b0:  32'sd1063911424, b1: -32'sd2127822848, b2: 32'sd1063911424,
                  a1:  32'sd2127560704, a2: -32'sd1054081024};
      3'd2: c = '{b0:  32'sd1049231360, b1: -32'sd2098462720, b2: 32'sd1049231360,
                  a1:  32'sd2097676288, a2: -32'sd1025245184};
      3'd3: c = '{b0:  32'sd1023410176, b1: -32'sd2046820352, b2: 32'sd1023410176,
                  a1:  32'sd2046820352, a2: -32'sd973078528};
      3'd4: c = '{b0:  32'sd981467136,  b1: -32'sd1962934272, b2: 32'sd981467136,
                  a1:  32'sd1946157056, a2: -32'sd889192448};
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/biquad_coeff_rom.sv
// biquad_coeff_rom
//   Registered coefficient lookup; one cycle from sel to coeffs.
//   clk_144  in   system clock
//   reset_n  in   async active-low reset
//   sel      in   latched cutoff select
//   coeffs   out  coefficient set for sel
module biquad_coeff_rom
  import biquad_pkg::*;
(
  input  logic       clk_144,
  input  logic       reset_n,
  input  logic [2:0] sel,
  output coeff_set_t coeffs
);

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) coeffs <= '0;
    else          coeffs <= coeff_lookup(sel);
  end

endmodule

// File: rtl/biquad_hpf_multich.sv
// biquad_hpf_multich
//   Time-multiplexed 2nd-order IIR high-pass over CH channels with one
//   shared multiplier: 5 MAC cycles + 1 writeback per channel.
//   Optional macro: BIQUAD_CLIP_FLAG_EN adds sticky per-channel clip flags.
//   clk_144     in   system clock
//   reset_n     in   async active-low reset
//   filter      in   cutoff select (0 bypass, 1..4 sets, 5..7 bypass)
//   in_valid    in   frame strobe, taken only while in_ready
//   in_ready    out  high in IDLE
//   sample_in   in   packed channel samples, ch0 in [W-1:0]
//   out_valid   out  one-cycle pulse when sample_out updates
//   sample_out  out  packed filtered samples, held between frames
//   clip_flag   out  sticky clip indicator per channel (macro only)
//   clip_clr    in   clears clip_flag; a same-cycle clip wins (macro only)
//
// state | meaning
// IDLE  | waiting for a frame, in_ready high
// LOAD  | coefficient ROM settling; history cleared on select change
// MAC   | five multiply-accumulate terms for channel ch_q
// WB    | saturate, update history, advance channel
// DONE  | out_valid pulse, sample_out holds the new frame
module biquad_hpf_multich
  import biquad_pkg::*;
#(
  parameter int CH    = 2,
  parameter int W     = 16,
  parameter int CW    = 32,
  parameter int FRAC  = 30,
  parameter int ACC_W = 64
) (
  input  logic            clk_144,
  input  logic            reset_n,
  input  logic [2:0]      filter,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] sample_in,
  output logic            out_valid,
  output logic [CH*W-1:0] sample_out
`ifdef BIQUAD_CLIP_FLAG_EN
  ,
  output logic [CH-1:0]   clip_flag,
  input  logic            clip_clr
`endif
);

  localparam int CH_IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW    = CW + W;
  localparam logic [2:0] K_FIRST = 3'd4;
  localparam logic signed [ACC_W-1:0] SAT_HI = (ACC_W'(1) <<< (W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;

  state_t                   state_q, state_d;
  logic [2:0]               sel_q, prev_sel;
  coeff_set_t               coeffs;
  logic [2:0]               mac_cnt;
  logic [CH_IW-1:0]         ch_q;
  logic                     last_ch;
  logic signed [ACC_W-1:0]  acc_q, acc_next, term;
  logic signed [CW-1:0]     coef_op;
  logic signed [W-1:0]      data_op;
  logic signed [PW-1:0]     prod;
  logic signed [W-1:0]      sat_val;
  logic signed [W-1:0]      x0_q [CH];
  logic signed [W-1:0]      x1_q [CH];
  logic signed [W-1:0]      x2_q [CH];
  logic signed [W-1:0]      y1_q [CH];
  logic signed [W-1:0]      y2_q [CH];

  biquad_coeff_rom u_coeff_rom (
    .clk_144 (clk_144),
    .reset_n (reset_n),
    .sel     (sel_q),
    .coeffs  (coeffs)
  );

  assign in_ready = (state_q == IDLE);
  assign last_ch  = (ch_q == CH_IW'(CH - 1));

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = MAC;
      MAC:     if (mac_cnt == 3'd0) state_d = WB;
      WB:      state_d = last_ch ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mac_cnt counts down 4..0; the term order is b0*x0, b1*x1, b2*x2, a1*y1, a2*y2.
  always_comb begin
    coef_op = coeffs.b0;
    data_op = x0_q[ch_q];
    case (mac_cnt)
      3'd3: begin coef_op = coeffs.b1; data_op = x1_q[ch_q]; end
      3'd2: begin coef_op = coeffs.b2; data_op = x2_q[ch_q]; end
      3'd1: begin coef_op = coeffs.a1; data_op = y1_q[ch_q]; end
      3'd0: begin coef_op = coeffs.a2; data_op = y2_q[ch_q]; end
      default: ;
    endcase
  end

  assign prod     = coef_op * data_op;
  assign term     = ACC_W'(prod >>> FRAC);
  assign acc_next = (mac_cnt == K_FIRST) ? term : acc_q + term;

  // Symmetric clamp: the most negative code is never produced.
  always_comb begin
    sat_val = acc_q[W-1:0];
    if (acc_q > SAT_HI)      sat_val = SAT_HI[W-1:0];
    else if (acc_q < SAT_LO) sat_val = SAT_LO[W-1:0];
  end

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= '0;
      prev_sel   <= '0;
      mac_cnt    <= K_FIRST;
      ch_q       <= '0;
      acc_q      <= '0;
      out_valid  <= 1'b0;
      sample_out <= '0;
      for (int c = 0; c < CH; c++) begin
        x0_q[c] <= '0;
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int c = 0; c < CH; c++) x0_q[c] <= sample_in[c*W +: W];
            sel_q <= (filter <= SEL_MAX) ? filter : 3'd0;
          end
        end
        LOAD: begin
          mac_cnt <= K_FIRST;
          ch_q    <= '0;
          if (sel_q != prev_sel) begin
            prev_sel <= sel_q;
            for (int c = 0; c < CH; c++) begin
              x1_q[c] <= '0;
              x2_q[c] <= '0;
              y1_q[c] <= '0;
              y2_q[c] <= '0;
            end
          end
        end
        MAC: begin
          acc_q <= acc_next;
          if (mac_cnt != 3'd0) mac_cnt <= mac_cnt - 3'd1;
        end
        WB: begin
          x2_q[ch_q] <= x1_q[ch_q];
          x1_q[ch_q] <= x0_q[ch_q];
          y2_q[ch_q] <= y1_q[ch_q];
          y1_q[ch_q] <= sat_val;
          mac_cnt    <= K_FIRST;
          ch_q       <= ch_q + 1'b1;
          if (last_ch) begin
            out_valid <= 1'b1;
            // y1_q of the current channel is only written this edge, so take sat_val directly.
            for (int c = 0; c < CH; c++)
              sample_out[c*W +: W] <= (CH_IW'(c) == ch_q) ? sat_val : y1_q[c];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIQUAD_CLIP_FLAG_EN
  logic clip_now;
  assign clip_now = (acc_q > SAT_HI) || (acc_q < SAT_LO);

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      clip_flag <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (state_q == WB && ch_q == CH_IW'(c) && clip_now) clip_flag[c] <= 1'b1;
        else if (clip_clr)                                  clip_flag[c] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_biquad_hpf_multich.sv
module tb_biquad_hpf_multich;

  localparam int CH = 2;
  localparam int W  = 16;

  logic            clk_144 = 1'b0;
  logic            reset_n = 1'b0;
  logic [2:0]      filter = 3'd0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CH*W-1:0] sample_in = '0;
  logic            out_valid;
  logic [CH*W-1:0] sample_out;
`ifdef BIQUAD_CLIP_FLAG_EN
  logic [CH-1:0]   clip_flag;
  logic            clip_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  biquad_hpf_multich dut (
    .clk_144    (clk_144),
    .reset_n    (reset_n),
    .filter     (filter),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sample_in  (sample_in),
    .out_valid  (out_valid),
    .sample_out (sample_out)
`ifdef BIQUAD_CLIP_FLAG_EN
    ,
    .clip_flag  (clip_flag),
    .clip_clr   (clip_clr)
`endif
  );

  always #5 clk_144 = ~clk_144;

  function automatic logic signed [15:0] och(input int c);
    return sample_out[c*W +: W];
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sends one frame, checks accept-to-out_valid latency and the one-cycle pulse.
  task automatic run_frame(input string tag, input logic [2:0] f,
                           input logic signed [15:0] a, input logic signed [15:0] b);
    int lat;
    @(negedge clk_144);
    chk({tag, "_ready"}, in_ready, 1);
    filter = f;
    sample_in = {b, a};
    in_valid = 1'b1;
    @(posedge clk_144); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk_144); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 14);
    chk({tag, "_busy"}, in_ready, 0);
    @(posedge clk_144); #1;
    chk({tag, "_pulse"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int nv, lat, first, second;
    bit armed;

    // reset state
    repeat (3) @(posedge clk_144);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", sample_out, 0);
`ifdef BIQUAD_CLIP_FLAG_EN
    chk("rst_clip", clip_flag, 0);
`endif
    @(negedge clk_144);
    reset_n = 1'b1;

    // 1: bypass passes samples through
    run_frame("t1", 3'd0, 16'sd1000, -16'sd1000);
    chk("t1_ch0", och(0), 1000);
    chk("t1_ch1", och(1), -1000);

    // 2: 500 Hz impulse response on ch0 (third value exercises floor of >>>)
    run_frame("t2a", 3'd3, 16'sd16384, 16'sd0);
    chk("t2a_ch0", och(0), 15616);
    chk("t2a_ch1", och(1), 0);
    run_frame("t2b", 3'd3, 16'sd0, 16'sd0);
    chk("t2b_ch0", och(0), -1464);
    chk("t2b_ch1", och(1), 0);
    run_frame("t2c", 3'd3, 16'sd0, 16'sd0);
    chk("t2c_ch0", och(0), -1327);
    chk("t2c_ch1", och(1), 0);

    // 3: most negative input clamps symmetrically, max positive passes
    run_frame("t3", 3'd0, -16'sd32768, 16'sd32767);
    chk("t3_ch0", och(0), -32767);
    chk("t3_ch1", och(1), 32767);
`ifdef BIQUAD_CLIP_FLAG_EN
    chk("t3_clip", clip_flag, 1);
    @(negedge clk_144);
    clip_clr = 1'b1;
    @(negedge clk_144);
    clip_clr = 1'b0;
    chk("t3_clip_clr", clip_flag, 0);
`endif

    // 4: in_valid while busy is dropped; exactly one out_valid
    @(negedge clk_144);
    chk("t4_ready", in_ready, 1);
    filter = 3'd0;
    sample_in = {-16'sd7, 16'sd123};
    in_valid = 1'b1;
    @(posedge clk_144); #1;
    in_valid = 1'b0;
    nv = 0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_144); #1;
      if (out_valid) begin
        nv++;
        if (lat == 0) lat = i + 1;
      end
      if (i == 2) begin
        in_valid = 1'b1;
        sample_in = {16'sd999, 16'sd999};
        chk("t4_busy_ready", in_ready, 0);
      end
      if (i == 3) in_valid = 1'b0;
    end
    chk("t4_lat", lat, 14);
    chk("t4_nvalid", nv, 1);
    chk("t4_ch0", och(0), 123);
    chk("t4_ch1", och(1), -7);

    // 4b: in_valid held through DONE is taken only the cycle after DONE
    @(negedge clk_144);
    filter = 3'd0;
    sample_in = {16'sd11, 16'sd22};
    in_valid = 1'b1;
    @(posedge clk_144); #1;
    sample_in = {16'sd33, 16'sd44};
    first = -1;
    second = -1;
    armed = 1'b0;
    for (int i = 1; i <= 60 && second < 0; i++) begin
      @(posedge clk_144); #1;
      if (out_valid) begin
        if (first < 0) begin
          first = i;
          chk("t4b_f1_ch0", och(0), 22);
          chk("t4b_f1_ch1", och(1), 11);
        end else begin
          second = i;
        end
      end
      if (armed) in_valid = 1'b0;
      if (in_ready && first >= 0 && in_valid) armed = 1'b1;
    end
    in_valid = 1'b0;
    chk("t4b_gap", second - first, 15);
    chk("t4b_f2_ch0", och(0), 44);
    chk("t4b_f2_ch1", och(1), 33);
    repeat (2) @(posedge clk_144);

    // 5: select change clears history
    run_frame("t5a", 3'd3, 16'sd16384, 16'sd0);
    chk("t5a_ch0", och(0), 15616);
    run_frame("t5b", 3'd4, 16'sd0, 16'sd0);
    chk("t5b_ch0", och(0), 0);
    chk("t5b_ch1", och(1), 0);

    // 6: reset during ch1 MAC aborts the frame
    run_frame("t6a", 3'd0, 16'sd77, 16'sd88);
    chk("t6a_ch0", och(0), 77);
    @(negedge clk_144);
    filter = 3'd0;
    sample_in = {16'sd5, 16'sd6};
    in_valid = 1'b1;
    @(posedge clk_144); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk_144);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_out", sample_out, 0);
    chk("t6_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk_144);
    reset_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_144); #1;
      if (out_valid) nv++;
    end
    chk("t6_no_valid", nv, 0);
    chk("t6_out_zero", sample_out, 0);
    run_frame("t6b", 3'd0, 16'sd500, -16'sd500);
    chk("t6b_ch0", och(0), 500);
    chk("t6b_ch1", och(1), -500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
